// File: rtl/seg_to_hex_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_to_hex_capture
// Purpose  : Watches an active-low 7-segment bus and turns each new stable
//            pattern back into a hex digit, blank or invalid event. Events are
//            held in a one-entry valid/ready output register.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous, active-high reset
//            seg_in     - active-low segments, [0]=a .. [6]=g, may be async
//            out_hex    - decoded digit (0 unless out_kind = 00)
//            out_kind   - 00 hex, 01 blank, 10 invalid
//            out_pat    - raw stable pattern for the event, active-low
//            out_valid  - event pending
//            out_ready  - consumer accepts when out_valid & out_ready
//            overflow   - sticky, an event was dropped under backpressure
// Revision : 1.0 - initial release
// ============================================================================
module seg_to_hex_capture #(
    parameter int STABLE_CYCLES = 4   // legal range 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:6] seg_in,
    output logic [3:0] out_hex,
    output logic [1:0] out_kind,
    output logic [0:6] out_pat,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow
);

    localparam logic [0:6] c_blank      = 7'b1111111;
    localparam logic [7:0] c_stable     = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_fire       = 8'(STABLE_CYCLES - 1);
    localparam logic [1:0] c_kind_hex   = 2'b00;
    localparam logic [1:0] c_kind_blank = 2'b01;
    localparam logic [1:0] c_kind_inv   = 2'b10;

    logic [0:6] r_sync1;
    logic [0:6] r_sync2;     // synchronized bus, the only view used downstream
    logic [0:6] r_prev;      // r_sync2 one cycle ago
    logic [7:0] r_cnt;       // consecutive cycles r_sync2 has held
    logic [0:6] r_last;      // last pattern that produced an event
    logic [3:0] r_hex;
    logic [1:0] r_kind;
    logic [0:6] r_pat;
    logic       r_valid;
    logic       r_overflow;

    logic       w_same;
    logic       w_event;
    logic       w_is_digit;
    logic [3:0] w_hex;
    logic [1:0] w_kind;

    // The counter reaches STABLE_CYCLES on the edge where it currently sits
    // one below and the pattern held again; that edge is the event edge.
    assign w_same  = (r_sync2 == r_prev);
    assign w_event = w_same && (r_cnt == c_fire) && (r_sync2 != r_last);

    always_comb begin
        w_hex      = 4'h0;
        w_is_digit = 1'b1;
        case (r_sync2)
            7'b0000001: w_hex = 4'h0;
            7'b1001111: w_hex = 4'h1;
            7'b0010010: w_hex = 4'h2;
            7'b0000110: w_hex = 4'h3;
            7'b1001100: w_hex = 4'h4;
            7'b0100100: w_hex = 4'h5;
            7'b0100000: w_hex = 4'h6;
            7'b0001111: w_hex = 4'h7;
            7'b0000000: w_hex = 4'h8;
            7'b0001100: w_hex = 4'h9;
            7'b0001000: w_hex = 4'hA;
            7'b1100000: w_hex = 4'hB;
            7'b0110001: w_hex = 4'hC;
            7'b1000010: w_hex = 4'hD;
            7'b0110000: w_hex = 4'hE;
            7'b0111000: w_hex = 4'hF;
            default:    w_is_digit = 1'b0;
        endcase
        if (w_is_digit) begin
            w_kind = c_kind_hex;
        end else if (r_sync2 == c_blank) begin
            w_kind = c_kind_blank;
        end else begin
            w_kind = c_kind_inv;
        end
    end

    // Synchronizer, stability counter and last-reported pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= c_blank;
            r_sync2 <= c_blank;
            r_prev  <= c_blank;
            r_cnt   <= 8'd0;
            r_last  <= c_blank;
        end else begin
            r_sync1 <= seg_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (!w_same) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != c_stable) begin
                r_cnt <= r_cnt + 8'd1;
            end
            // Updated even when the event is dropped so it is never retried.
            if (w_event) begin
                r_last <= r_sync2;
            end
        end
    end

    // One-entry output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex      <= 4'h0;
            r_kind     <= c_kind_hex;
            r_pat      <= c_blank;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_event) begin
            if (!r_valid || out_ready) begin
                r_hex   <= w_hex;
                r_kind  <= w_kind;
                r_pat   <= r_sync2;
                r_valid <= 1'b1;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_hex   = r_hex;
    assign out_kind  = r_kind;
    assign out_pat   = r_pat;
    assign out_valid = r_valid;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seg_to_hex_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_to_hex_capture
// Purpose  : Self-checking bench for seg_to_hex_capture. A reference model
//            works on the raw per-edge samples of seg_in (run lengths of equal
//            samples) and pushes expected events into a queue; a monitor on
//            the falling edge compares whatever the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_to_hex_capture;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:6] seg_in;
    logic [3:0] out_hex;
    logic [1:0] out_kind;
    logic [0:6] out_pat;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    seg_to_hex_capture #(.STABLE_CYCLES(STABLE)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .out_hex   (out_hex),
        .out_kind  (out_kind),
        .out_pat   (out_pat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] hex;
        logic [1:0] kind;
        logic [0:6] pat;
    } ev_t;

    logic [0:6] digit_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int  n_cmp = 0;
    int  n_err = 0;
    int  pops  = 0;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ev_t decode(input logic [0:6] p);
        ev_t e;
        e.hex  = 4'h0;
        e.kind = 2'b10;
        e.pat  = p;
        if (p == 7'b1111111) e.kind = 2'b01;
        for (int i = 0; i < 16; i++) begin
            if (digit_tab[i] == p) begin
                e.hex  = 4'(i);
                e.kind = 2'b00;
            end
        end
        return e;
    endfunction

    // ---------------- reference model (rising edge) ----------------
    // A pattern is accepted once STABLE+1 consecutive edge samples agree;
    // the resulting event reaches the output register two edges later.
    int         run;
    logic [0:6] run_val;
    logic [0:6] last;
    logic       d1_v, d2_v;
    ev_t        d1_e, d2_e;
    logic       m_occ, m_ovf;

    always @(posedge clk) begin
        if (reset) begin
            run     = 0;
            run_val = 7'b1111111;
            last    = 7'b1111111;
            d1_v    = 1'b0;
            d2_v    = 1'b0;
            m_occ   = 1'b0;
            m_ovf   = 1'b0;
            exp_q.delete();
        end else begin
            if (d2_v) begin
                if (!m_occ || out_ready) begin
                    m_occ = 1'b1;
                    exp_q.push_back(d2_e);
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (out_ready) begin
                m_occ = 1'b0;
            end
            d2_v = d1_v;
            d2_e = d1_e;
            d1_v = 1'b0;
            if (seg_in != run_val) begin
                run_val = seg_in;
                run     = 1;
            end else if (run <= STABLE) begin
                run++;
                if (run == STABLE + 1 && run_val != last) begin
                    d1_v = 1'b1;
                    d1_e = decode(run_val);
                    last = run_val;
                end
            end
        end
    end

    // ---------------- monitor (falling edge) ----------------
    always @(negedge clk) begin
        check("valid", 32'(out_valid), 32'(m_occ));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected event pat", 32'(out_pat), 32'h1ff);
            end else begin
                check("event hex", 32'(out_hex), 32'(exp_q[0].hex));
                check("event kind", 32'(out_kind), 32'(exp_q[0].kind));
                check("event pat", 32'(out_pat), 32'(exp_q[0].pat));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        int lat;
        reset     = 1'b1;
        seg_in    = 7'b1111111;
        out_ready = 1'b1;
        tick(2);
        reset = 1'b0;
        check("reset hex", 32'(out_hex), 32'h0);
        check("reset kind", 32'(out_kind), 32'h0);
        check("reset pat", 32'(out_pat), 32'h7f);
        check("reset valid", 32'(out_valid), 32'h0);
        check("reset overflow", 32'(overflow), 32'h0);

        // digit 3 latency: first sample edge is the next rising edge (i=1)
        seg_in = 7'b0000110;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (out_valid && lat < 0) lat = i;
        end
        check("digit3 latency", 32'(lat - 1), 32'(STABLE + 2));

        // glitch rejection
        p0 = pops;
        seg_in = 7'b0010010; tick(10);
        seg_in = 7'b0000000; tick(2);
        seg_in = 7'b0010010; tick(10);
        check("glitch events", 32'(pops - p0), 32'd1);
        check("glitch overflow", 32'(overflow), 32'h0);

        // blank and invalid
        p0 = pops;
        seg_in = 7'b0100100; tick(10);
        seg_in = 7'b1111111; tick(10);
        seg_in = 7'b1111110; tick(10);
        check("blank/invalid events", 32'(pops - p0), 32'd3);

        // backpressure
        p0 = pops;
        out_ready = 1'b0;
        seg_in = 7'b0001000; tick(10);
        seg_in = 7'b0111000; tick(10);
        check("bp hex held", 32'(out_hex), 32'hA);
        check("bp valid held", 32'(out_valid), 32'h1);
        check("bp overflow", 32'(overflow), 32'h1);
        out_ready = 1'b1;
        tick(1);
        check("bp valid drop", 32'(out_valid), 32'h0);
        tick(10);
        check("bp events", 32'(pops - p0), 32'd1);

        // simultaneous accept and new event
        reset = 1'b1; tick(1); reset = 1'b0;
        out_ready = 1'b0;
        seg_in = 7'b1100000; tick(10);
        seg_in = 7'b0110001;          // first sampled at edge P+1, event at P+7
        tick(6);
        out_ready = 1'b1;
        tick(1);
        check("simul valid", 32'(out_valid), 32'h1);
        check("simul hex", 32'(out_hex), 32'hC);
        check("simul overflow", 32'(overflow), 32'h0);
        tick(10);

        // reset mid-count
        seg_in = 7'b0001111; tick(3);
        reset = 1'b1; tick(1); reset = 1'b0;
        check("midrst pat", 32'(out_pat), 32'h7f);
        check("midrst valid", 32'(out_valid), 32'h0);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (out_valid && lat < 0) lat = i;
        end
        check("midrst latency", 32'(lat - 1), 32'(STABLE + 2));

        // randomized traffic
        for (int seg = 0; seg < 400; seg++) begin
            int sel;
            int hold;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       seg_in = digit_tab[$urandom_range(0, 15)];
            else if (sel == 6) seg_in = 7'b1111111;
            else if (sel < 9)  seg_in = 7'($urandom());
            hold = int'($urandom_range(1, 9));
            for (int c = 0; c < hold; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                reset     = ($urandom_range(0, 199) == 0);
                tick(1);
            end
        end
        reset     = 1'b0;
        out_ready = 1'b1;
        tick(20);
        check("queue drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
